// File: rtl/branch_pc_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_pc_if : request/response bundle between the issuing stage and the   |
// |                branch_pc_unit.          Revision: 1.0                       |
// +----------------------------------------------------------------------------+
interface branch_pc_if;
  logic        start;
  logic [2:0]  br_op;
  logic [31:0] offset;
  logic [25:0] instr_index;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] pc;
  logic        busy;
  logic        done;
  logic        taken;
  logic        link_we;
  logic [31:0] link_addr;
  logic        misalign;

  modport master (
    output start, br_op, offset, instr_index, rs_val, rt_val,
    input  pc, busy, done, taken, link_we, link_addr, misalign
  );

  modport slave (
    input  start, br_op, offset, instr_index, rs_val, rt_val,
    output pc, busy, done, taken, link_we, link_addr, misalign
  );
endinterface
`default_nettype wire

// File: rtl/branch_pc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_pc_unit : four-state next-PC resolver for seq/branch/jump ops.      |
// |                  Revision: 1.0                                             |
// +----------------------------------------------------------------------------+
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input logic        clk,
  input logic        rst_n,
  branch_pc_if.slave bus
);

  localparam logic [2:0] c_OP_BEQ  = 3'b001;
  localparam logic [2:0] c_OP_BNE  = 3'b010;
  localparam logic [2:0] c_OP_BGEZ = 3'b011;
  localparam logic [2:0] c_OP_J    = 3'b100;
  localparam logic [2:0] c_OP_JAL  = 3'b101;
  localparam logic [2:0] c_OP_JR   = 3'b110;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    EVAL   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_accept;
  logic   w_calc;
  logic   w_eval;
  logic   w_commit;

  logic [2:0]  r_op;
  logic [31:0] r_off;
  logic [25:0] r_idx;
  logic [31:0] r_rs;
  logic [31:0] r_rt;
  logic [31:0] r_pc4;
  logic [31:0] r_btgt;
  logic [31:0] r_next;
  logic        r_sel_taken;
  logic        r_sel_link;
  logic        r_sel_mis;
  logic [31:0] r_pc;
  logic        r_busy;
  logic        r_done;
  logic        r_taken;
  logic        r_link_we;
  logic [31:0] r_link_addr;
  logic        r_misalign;

  logic [31:0] w_next;
  logic        w_taken;
  logic        w_link;
  logic        w_mis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_calc      = 1'b0;
    w_eval      = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        w_calc      = 1'b1;
        w_state_nxt = EVAL;
      end
      EVAL: begin
        w_eval      = 1'b1;
        w_state_nxt = COMMIT;
      end
      COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Target selection from the latched operands; a misaligned jr falls through.
  always_comb begin
    w_next  = r_pc4;
    w_taken = 1'b0;
    w_link  = 1'b0;
    w_mis   = 1'b0;
    case (r_op)
      c_OP_BEQ:  if (r_rs == r_rt) begin w_next = r_btgt; w_taken = 1'b1; end
      c_OP_BNE:  if (r_rs != r_rt) begin w_next = r_btgt; w_taken = 1'b1; end
      c_OP_BGEZ: if (!r_rs[31])    begin w_next = r_btgt; w_taken = 1'b1; end
      c_OP_J: begin
        w_next  = {r_pc4[31:28], r_idx, 2'b00};
        w_taken = 1'b1;
      end
      c_OP_JAL: begin
        w_next  = {r_pc4[31:28], r_idx, 2'b00};
        w_taken = 1'b1;
        w_link  = 1'b1;
      end
      c_OP_JR: begin
        if (r_rs[1:0] != 2'b00) begin
          w_mis = 1'b1;
        end else begin
          w_next  = r_rs;
          w_taken = 1'b1;
        end
      end
      default: w_next = r_pc4;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= 3'd0;
      r_off       <= 32'd0;
      r_idx       <= 26'd0;
      r_rs        <= 32'd0;
      r_rt        <= 32'd0;
      r_pc4       <= 32'd0;
      r_btgt      <= 32'd0;
      r_next      <= 32'd0;
      r_sel_taken <= 1'b0;
      r_sel_link  <= 1'b0;
      r_sel_mis   <= 1'b0;
      r_pc        <= RESET_PC;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_taken     <= 1'b0;
      r_link_we   <= 1'b0;
      r_link_addr <= 32'd0;
      r_misalign  <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_taken    <= 1'b0;
      r_link_we  <= 1'b0;
      r_misalign <= 1'b0;

      if (w_accept) begin
        r_op  <= bus.br_op;
        r_off <= bus.offset;
        r_idx <= bus.instr_index;
        r_rs  <= bus.rs_val;
        r_rt  <= bus.rt_val;
      end

      if (w_calc) begin
        r_pc4  <= r_pc + 32'd4;
        r_btgt <= r_pc + 32'd4 + r_off;
      end

      if (w_eval) begin
        r_next      <= w_next;
        r_sel_taken <= w_taken;
        r_sel_link  <= w_link;
        r_sel_mis   <= w_mis;
      end

      // Leaving COMMIT loads pc; the result flags are visible the cycle after.
      if (w_commit) begin
        r_pc        <= r_next;
        r_done      <= 1'b1;
        r_taken     <= r_sel_taken;
        r_link_we   <= r_sel_link;
        r_misalign  <= r_sel_mis;
        r_link_addr <= r_pc4;
      end

      // Busy spans from the cycle after acceptance through the done cycle.
      if (w_accept)    r_busy <= 1'b1;
      else if (r_done) r_busy <= 1'b0;
    end
  end

  assign bus.pc        = r_pc;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.taken     = r_taken;
  assign bus.link_we   = r_link_we;
  assign bus.link_addr = r_link_addr;
  assign bus.misalign  = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_branch_pc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_branch_pc_unit : directed and random checks of branch_pc_unit against  |
// |                     a next-PC reference model.   Revision: 1.0            |
// +----------------------------------------------------------------------------+
module tb_branch_pc_unit;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [31:0] m_pc;

  branch_pc_if bus ();

  branch_pc_unit #(.RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: next PC from the instruction semantics.
  function automatic void model(input logic [31:0] cur, input logic [2:0] op,
                                input logic [31:0] off, input logic [25:0] idx,
                                input logic [31:0] rs, input logic [31:0] rt,
                                output logic [31:0] nxt, output logic tk,
                                output logic lk, output logic ms);
    logic [31:0] seq_pc;
    logic [31:0] br_pc;
    logic [31:0] jmp_pc;
    logic        cond;
    seq_pc = cur + 32'd4;
    br_pc  = seq_pc + off;
    jmp_pc = (seq_pc & 32'hF000_0000) | ({6'd0, idx} * 32'd4);
    nxt = seq_pc; tk = 1'b0; lk = 1'b0; ms = 1'b0;
    cond = 1'b0;
    if (op == 3'd1) cond = (rs == rt);
    if (op == 3'd2) cond = (rs != rt);
    if (op == 3'd3) cond = ($signed(rs) >= 0);
    if (cond) begin nxt = br_pc; tk = 1'b1; end
    if (op == 3'd4 || op == 3'd5) begin nxt = jmp_pc; tk = 1'b1; lk = (op == 3'd5); end
    if (op == 3'd6) begin
      if ((rs % 4) != 0) ms = 1'b1;
      else begin nxt = rs; tk = 1'b1; end
    end
  endfunction

  task automatic scramble();
    bus.br_op       = 3'($urandom);
    bus.offset      = $urandom;
    bus.instr_index = 26'($urandom);
    bus.rs_val      = $urandom;
    bus.rt_val      = $urandom;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] off, input logic [25:0] idx,
                       input logic [31:0] rs, input logic [31:0] rt);
    logic [31:0] e_pc;
    logic e_tk, e_lk, e_ms;
    model(m_pc, op, off, idx, rs, rt, e_pc, e_tk, e_lk, e_ms);
    bus.start = 1'b1; bus.br_op = op; bus.offset = off;
    bus.instr_index = idx; bus.rs_val = rs; bus.rt_val = rt;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      chk("busy_mid", {31'd0, bus.busy}, 32'd1);
      chk("done_early", {31'd0, bus.done}, 32'd0);
      chk("pc_hold", bus.pc, m_pc);
      scramble();
      bus.start = 1'($urandom);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    chk("done", {31'd0, bus.done}, 32'd1);
    chk("busy_done", {31'd0, bus.busy}, 32'd1);
    chk("pc", bus.pc, e_pc);
    chk("taken", {31'd0, bus.taken}, {31'd0, e_tk});
    chk("link_we", {31'd0, bus.link_we}, {31'd0, e_lk});
    chk("misalign", {31'd0, bus.misalign}, {31'd0, e_ms});
    if (e_lk) chk("link_addr", bus.link_addr, m_pc + 32'd4);
    m_pc = e_pc;
    @(posedge clk); #1;
    chk("done_after", {31'd0, bus.done}, 32'd0);
    chk("busy_after", {31'd0, bus.busy}, 32'd0);
    chk("pc_after", bus.pc, m_pc);
  endtask

  task automatic set_pc(input logic [31:0] v);
    do_op(3'd6, 32'd0, 26'd0, v, 32'd0);
  endtask

  initial begin
    logic [15:0] imm;
    logic [31:0] rs;
    total = 0; bad = 0;
    rst_n = 1'b0; bus.start = 1'b0;
    scramble();
    m_pc = RESET_PC;
    #12;
    chk("rst_pc", bus.pc, RESET_PC);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_link_addr", bus.link_addr, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    do_op(3'd0, 32'd0, 26'd0, 32'd0, 32'd0);
    chk("seq_pc", bus.pc, 32'h0040_0004);

    set_pc(32'h0040_0010);
    do_op(3'd1, 32'hFFFF_FFF0, 26'd0, 32'd5, 32'd5);
    chk("beq_t_pc", bus.pc, 32'h0040_0004);
    set_pc(32'h0040_0010);
    do_op(3'd1, 32'hFFFF_FFF0, 26'd0, 32'd5, 32'd6);
    chk("beq_nt_pc", bus.pc, 32'h0040_0014);

    set_pc(32'h0040_0000);
    do_op(3'd5, 32'd0, 26'h010_0008, 32'd0, 32'd0);
    chk("jal_pc", bus.pc, 32'h0040_0020);

    do_op(3'd6, 32'd0, 26'd0, 32'h0040_0102, 32'd0);
    chk("jr_mis_pc", bus.pc, 32'h0040_0024);
    do_op(3'd6, 32'd0, 26'd0, 32'h0040_0100, 32'd0);
    chk("jr_pc", bus.pc, 32'h0040_0100);

    set_pc(32'hFFFF_FFFC);
    do_op(3'd0, 32'd0, 26'd0, 32'd0, 32'd0);
    chk("wrap_pc", bus.pc, 32'h0000_0000);
    do_op(3'd3, 32'h0000_0100, 26'd0, 32'h8000_0000, 32'd0);
    chk("bgez_nt_pc", bus.pc, 32'h0000_0004);

    for (int i = 0; i < 40; i++) begin
      imm = 16'($urandom);
      rs  = $urandom;
      do_op(3'($urandom_range(0, 7)), {{14{imm[15]}}, imm, 2'b00}, 26'($urandom), rs,
            ($urandom_range(0, 1) == 1) ? rs : $urandom);
    end

    // Abort mid-operation: reset during EVAL must leave no trace.
    bus.start = 1'b1; bus.br_op = 3'd4; bus.instr_index = 26'h123_4567;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_pc", bus.pc, RESET_PC);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_link_addr", bus.link_addr, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    m_pc = RESET_PC;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("abort_no_done", {31'd0, bus.done}, 32'd0);
      chk("abort_pc_hold", bus.pc, RESET_PC);
    end
    do_op(3'd0, 32'd0, 26'd0, 32'd0, 32'd0);
    chk("post_abort_pc", bus.pc, RESET_PC + 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/branch_pc_unit.md
BRANCH_PC_UNIT -- requirements
Module: branch_pc_unit

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter: RESET_PC, 32'h0040_0000, PC value loaded on reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  request to resolve next PC for current instruction; sampled only in IDLE.
REQ-006 br_op  in  3  000 seq, 001 beq, 010 bne, 011 bgez, 100 j, 101 jal, 110 jr, 111 treated as seq.
REQ-007 offset  in  32  sign-extended, pre-shifted (<<2) branch offset from immediate extender.
REQ-008 instr_index  in  26  jump target field.
REQ-009 rs_val  in  32  register rs operand.
REQ-010 rt_val  in  32  register rt operand.
REQ-011 pc  out  32  current program counter (registered).
REQ-012 busy  out  1  high from cycle after accepted start until done cycle inclusive.
REQ-013 done  out  1  one-cycle pulse; new pc valid in same cycle.
REQ-014 taken  out  1  valid with done; 1 when pc redirected away from pc+4.
REQ-015 link_we  out  1  one-cycle pulse with done for jal only.
REQ-016 link_addr  out  32  pc+4 of resolved instruction; valid while link_we high.
REQ-017 misalign  out  1  one-cycle pulse with done when jr target bits[1:0] != 0.

Function
REQ-018 FSM states SHALL be IDLE, CALC, EVAL, COMMIT; transitions IDLE->CALC on start, CALC->EVAL, EVAL->COMMIT, COMMIT->IDLE unconditionally.
REQ-019 On accepted start (IDLE, start=1) br_op, offset, instr_index, rs_val, rt_val SHALL be latched at that edge; later input changes have no effect.
REQ-020 start while not IDLE SHALL be ignored, not queued.
REQ-021 CALC SHALL compute pc4 = pc+4 and btgt = pc4+offset, both modulo 2^32 (carry out discarded).
REQ-022 EVAL SHALL select next: beq rs==rt, bne rs!=rt, bgez rs[31]==0 -> btgt else pc4; j/jal -> {pc4[31:28], instr_index, 2'b00}; jr -> rs_val; seq -> pc4.
REQ-023 jr with rs_val[1:0] != 0 SHALL select pc4 and flag misalign; taken=0.
REQ-024 COMMIT edge SHALL load pc with selected value and assert done, taken, link_we, misalign for exactly that cycle.
REQ-025 Latency: start sampled at edge N -> done high in cycle after edge N+3, pc updated at edge N+3.
REQ-026 taken SHALL be 1 iff selected next != pc4 path was chosen (conditional true, j, jal, aligned jr), even if target numerically equals pc4.
REQ-027 pc SHALL change only at COMMIT edge or reset.
REQ-028 done, taken, link_we, misalign SHALL be 0 in all non-COMMIT states.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, pc=RESET_PC, busy=0, done=0, taken=0, link_we=0, misalign=0, link_addr=0, latched operands=0.
REQ-030 Reset asserted mid-operation SHALL abort with no pc update; first start after release behaves as from clean reset.
REQ-031 Release of rst_n SHALL be synchronised by the integrator; block accepts start on the first edge after release.

Verification
REQ-032 Reset, then start br_op=000 -> done 3 edges later, pc=0x0040_0004, taken=0.
REQ-033 pc=0x0040_0010, beq, rs=rt=5, offset=0xFFFF_FFF0 -> pc=0x0040_0004, taken=1; repeat with rs=5, rt=6 -> pc=0x0040_0014, taken=0.
REQ-034 pc=0x0040_0000, jal, instr_index=0x010_0008 -> pc=0x0040_0020, link_we=1, link_addr=0x0040_0004.
REQ-035 jr rs_val=0x0040_0102 -> misalign=1, pc=old pc+4, taken=0; jr rs_val=0x0040_0100 -> pc=0x0040_0100, taken=1.
REQ-036 pc=0xFFFF_FFFC, br_op=000 -> pc=0x0000_0000 (wrap); bgez rs=0x8000_0000 -> not taken.
REQ-037 Start accepted, rst_n pulsed low during EVAL -> pc=RESET_PC, no done pulse; start while busy ignored (single done observed).
